// File: rtl/spi_sphere_receiver_pkg.sv
// Shared types for the SPI sphere receiver: frame width, descriptor word,
// delivery FSM states and the status byte layout returned on MISO.
package spi_sphere_receiver_pkg;

  localparam int SPHERE_FRAME_B = 64;
  localparam int BIT_CNT_W      = $clog2(SPHERE_FRAME_B);

  typedef logic [SPHERE_FRAME_B-1:0] Sphere_Word;

  typedef enum logic [1:0] {
    RECV_IDLE,
    RECV_ARMED,
    RECV_DELIVER,
    RECV_WAIT_LOW
  } Recv_State;

  // Status byte seen by the host: sticky flags on top, FIFO occupancy below.
  function automatic logic [7:0] make_status(input logic ovf,
                                             input logic ferr,
                                             input logic [3:0] count);
    return {ovf, ferr, 2'b00, count};
  endfunction

endpackage

// File: rtl/spi_sphere_receiver_sync_fifo.sv
// Small first-word-fall-through FIFO. A pop and a push in the same cycle on a
// full FIFO both succeed, because the pop frees the slot the push needs.
module sync_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       din,
  output logic [WIDTH-1:0]       dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; pointers wrap naturally (power-of-two depth).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (!do_push && do_pop) count <= count - 1'b1;
    end
  end

  // Storage array, no reset needed since entries are only read once written.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/spi_sphere_receiver.sv
// SPI slave that deserialises 64-bit sphere descriptors, queues them, and
// hands at most one to the raytracing controller per recv_interrupt pulse.
module spi_sphere_receiver
  import spi_sphere_receiver_pkg::*;
#(
  parameter int FIFO_DEPTH  = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic        CLK100MHZ,
  input  logic        ck_rst,
  input  logic        spi_sclk,
  input  logic        spi_mosi,
  input  logic        spi_cs_n,
  output logic        spi_miso,
  input  logic        recv_interrupt,
  output logic        recv_dv,
  output logic [63:0] recv_64bit,
  output logic        overflow,
  output logic        frame_error,
  input  logic        clear_errors
);

  logic [SYNC_STAGES-1:0]      sclk_sync, mosi_sync, cs_sync;
  logic                        sclk_prev, cs_prev;
  logic                        sclk_s, mosi_s, cs_s;
  logic                        sclk_rise, sclk_fall, cs_fall, cs_rise, cs_active;
  Sphere_Word                  shift_reg;
  Sphere_Word                  fifo_din, fifo_dout;
  logic [BIT_CNT_W-1:0]        bit_cnt;
  logic                        frame_done, fifo_pop, fifo_full, fifo_empty;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;
  logic [3:0]                  count_nib;
  logic                        overflow_evt, abort_evt;
  logic [7:0]                  status_sr, status_now;
  logic                        int_q, int_q_d;
  Recv_State                   state;

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign cs_s      = cs_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_prev;
  assign sclk_fall = ~sclk_s & sclk_prev;
  assign cs_fall   = ~cs_s & cs_prev;
  assign cs_rise   = cs_s & ~cs_prev;
  assign cs_active = ~cs_s;

  // Bring the SPI pins into the system clock domain; CS idles high.
  always_ff @(posedge CLK100MHZ or posedge ck_rst) begin
    if (ck_rst) begin
      sclk_sync <= '0;
      mosi_sync <= '0;
      cs_sync   <= '1;
      sclk_prev <= 1'b0;
      cs_prev   <= 1'b1;
    end else begin
      sclk_sync <= (sclk_sync << 1) | SYNC_STAGES'(spi_sclk);
      mosi_sync <= (mosi_sync << 1) | SYNC_STAGES'(spi_mosi);
      cs_sync   <= (cs_sync << 1) | SYNC_STAGES'(spi_cs_n);
      sclk_prev <= sclk_s;
      cs_prev   <= cs_s;
    end
  end

  assign frame_done = sclk_rise && cs_active && (bit_cnt == BIT_CNT_W'(SPHERE_FRAME_B-1));
  assign fifo_din   = {shift_reg[SPHERE_FRAME_B-2:0], mosi_s};

  // Shift MOSI in on each SCLK rise; an early CS release discards the partial frame.
  always_ff @(posedge CLK100MHZ or posedge ck_rst) begin
    if (ck_rst) begin
      shift_reg <= '0;
      bit_cnt   <= '0;
    end else if (sclk_rise && cs_active) begin
      shift_reg <= fifo_din;
      bit_cnt   <= bit_cnt + 1'b1;
    end else if (cs_rise) begin
      bit_cnt <= '0;
    end
  end

  sync_fifo #(
    .WIDTH (SPHERE_FRAME_B),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (CLK100MHZ),
    .rst   (ck_rst),
    .push  (frame_done),
    .pop   (fifo_pop),
    .din   (fifo_din),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign overflow_evt = frame_done && fifo_full && !fifo_pop;
  assign abort_evt    = cs_rise && (bit_cnt != '0);

  // Sticky error flags; a new event in the same cycle beats a clear.
  always_ff @(posedge CLK100MHZ or posedge ck_rst) begin
    if (ck_rst) begin
      overflow    <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      if (overflow_evt)      overflow <= 1'b1;
      else if (clear_errors) overflow <= 1'b0;
      if (abort_evt)         frame_error <= 1'b1;
      else if (clear_errors) frame_error <= 1'b0;
    end
  end

  assign count_nib  = 4'(fifo_count);
  assign status_now = make_status(overflow, frame_error, count_nib);
  assign spi_miso   = cs_active & status_sr[7];

  // Status byte for the host: snapshot at CS fall and at every byte boundary.
  always_ff @(posedge CLK100MHZ or posedge ck_rst) begin
    if (ck_rst) begin
      status_sr <= '0;
    end else if (cs_fall) begin
      status_sr <= status_now;
    end else if (sclk_fall && cs_active) begin
      if (bit_cnt[2:0] == 3'd0) status_sr <= status_now;
      else                      status_sr <= {status_sr[6:0], 1'b0};
    end
  end

  // Registered copy of the request line so its rising edge can be detected.
  always_ff @(posedge CLK100MHZ or posedge ck_rst) begin
    if (ck_rst) begin
      int_q   <= 1'b0;
      int_q_d <= 1'b0;
    end else begin
      int_q   <= recv_interrupt;
      int_q_d <= int_q;
    end
  end

  assign fifo_pop = (state == RECV_ARMED) && !fifo_empty;

  // Delivery FSM: one descriptor per request pulse, then wait for the line to drop.
  always_ff @(posedge CLK100MHZ or posedge ck_rst) begin
    if (ck_rst) begin
      state      <= RECV_IDLE;
      recv_dv    <= 1'b0;
      recv_64bit <= '0;
    end else begin
      recv_dv <= 1'b0;
      case (state)
        RECV_IDLE: begin
          if (int_q && !int_q_d) state <= RECV_ARMED;
        end
        RECV_ARMED: begin
          if (!fifo_empty) begin
            recv_64bit <= fifo_dout;
            recv_dv    <= 1'b1;
            state      <= RECV_DELIVER;
          end else if (!int_q) begin
            state <= RECV_IDLE;
          end
        end
        RECV_DELIVER: begin
          state <= RECV_WAIT_LOW;
        end
        RECV_WAIT_LOW: begin
          if (!int_q) state <= RECV_IDLE;
        end
        default: state <= RECV_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_sphere_receiver.sv
// Self-checking bench for spi_sphere_receiver: a host-side SPI driver, a
// request driver and a scoreboard of descriptors expected from recv_64bit.
module tb_spi_sphere_receiver;

  localparam int  FIFO_DEPTH  = 4;
  localparam int  SYNC_STAGES = 2;
  localparam time CLK_P       = 10;
  localparam time HALF        = 50;

  logic        CLK100MHZ = 1'b0;
  logic        ck_rst = 1'b1;
  logic        spi_sclk = 1'b0;
  logic        spi_mosi = 1'b0;
  logic        spi_cs_n = 1'b1;
  logic        spi_miso;
  logic        recv_interrupt = 1'b0;
  logic        recv_dv;
  logic [63:0] recv_64bit;
  logic        overflow;
  logic        frame_error;
  logic        clear_errors = 1'b0;

  int          checks = 0;
  int          errors = 0;
  int          dv_count = 0;
  time         dv_time = 0;
  time         last_rise_t = 0;
  logic [7:0]  miso_byte = '0;
  logic [63:0] exp_q [$];

  spi_sphere_receiver #(
    .FIFO_DEPTH  (FIFO_DEPTH),
    .SYNC_STAGES (SYNC_STAGES)
  ) dut (
    .CLK100MHZ      (CLK100MHZ),
    .ck_rst         (ck_rst),
    .spi_sclk       (spi_sclk),
    .spi_mosi       (spi_mosi),
    .spi_cs_n       (spi_cs_n),
    .spi_miso       (spi_miso),
    .recv_interrupt (recv_interrupt),
    .recv_dv        (recv_dv),
    .recv_64bit     (recv_64bit),
    .overflow       (overflow),
    .frame_error    (frame_error),
    .clear_errors   (clear_errors)
  );

  always #(CLK_P/2) CLK100MHZ = ~CLK100MHZ;

  // Scoreboard: every strobe must match the oldest descriptor still expected.
  always @(posedge CLK100MHZ) begin
    #1;
    if (recv_dv === 1'b1) begin
      dv_count++;
      dv_time = $time;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("[TB] FAIL scoreboard_unexpected: got %h, none expected", recv_64bit);
      end else begin
        logic [63:0] exp_word;
        exp_word = exp_q.pop_front();
        if (recv_64bit !== exp_word) begin
          errors++;
          $display("[TB] FAIL scoreboard_data: got %h, expected %h", recv_64bit, exp_word);
        end
      end
    end
  end

  // Guard against a hung run.
  initial begin
    #(3ms);
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic cs_low();
    @(negedge CLK100MHZ);
    spi_cs_n = 1'b0;
    #(HALF);
  endtask

  task automatic cs_high();
    #(HALF);
    spi_cs_n = 1'b1;
    #(HALF*4);
  endtask

  // Mode 0 master: data set while SCLK low, MISO sampled just before the rise.
  task automatic send_bits(input logic [63:0] data, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      spi_mosi = data[63-i];
      #(HALF);
      if (i < 8) miso_byte = {miso_byte[6:0], spi_miso};
      spi_sclk = 1'b1;
      last_rise_t = $time;
      #(HALF);
      spi_sclk = 1'b0;
    end
  endtask

  task automatic send_frame(input logic [63:0] data);
    cs_low();
    send_bits(data, 64);
    cs_high();
  endtask

  task automatic pulse_request(input int expect_n, input string name);
    int start;
    int cyc;
    @(negedge CLK100MHZ);
    start = dv_count;
    recv_interrupt = 1'b1;
    cyc = 0;
    while (dv_count == start && cyc < 20) begin
      @(negedge CLK100MHZ);
      cyc++;
    end
    repeat (6) @(negedge CLK100MHZ);
    recv_interrupt = 1'b0;
    repeat (4) @(negedge CLK100MHZ);
    checks++;
    if (dv_count - start != expect_n) begin
      errors++;
      $display("[TB] FAIL %s: strobes %0d, expected %0d", name, dv_count - start, expect_n);
    end
  endtask

  task automatic pulse_clear();
    @(negedge CLK100MHZ);
    clear_errors = 1'b1;
    @(negedge CLK100MHZ);
    clear_errors = 1'b0;
    @(negedge CLK100MHZ);
  endtask

  task automatic test_reset();
    ck_rst = 1'b1;
    repeat (4) @(negedge CLK100MHZ);
    checks += 5;
    if (recv_dv !== 1'b0)      begin errors++; $display("[TB] FAIL reset_dv: got %b, expected 0", recv_dv); end
    if (spi_miso !== 1'b0)     begin errors++; $display("[TB] FAIL reset_miso: got %b, expected 0", spi_miso); end
    if (overflow !== 1'b0)     begin errors++; $display("[TB] FAIL reset_overflow: got %b, expected 0", overflow); end
    if (frame_error !== 1'b0)  begin errors++; $display("[TB] FAIL reset_frame_error: got %b, expected 0", frame_error); end
    if (recv_64bit !== 64'h0)  begin errors++; $display("[TB] FAIL reset_data: got %h, expected 0", recv_64bit); end
    ck_rst = 1'b0;
    repeat (4) @(negedge CLK100MHZ);
  endtask

  task automatic test_single_frame();
    time t0;
    int  start;
    exp_q.push_back(64'h0123_4567_89AB_CDEF);
    send_frame(64'h0123_4567_89AB_CDEF);
    @(negedge CLK100MHZ);
    start = dv_count;
    t0 = $time;
    recv_interrupt = 1'b1;
    repeat (10) @(negedge CLK100MHZ);
    recv_interrupt = 1'b0;
    repeat (4) @(negedge CLK100MHZ);
    checks += 5;
    if (dv_count - start != 1) begin
      errors++; $display("[TB] FAIL single_strobes: got %0d, expected 1", dv_count - start);
    end
    if (dv_time - t0 != 2*CLK_P + CLK_P/2 + 1) begin
      errors++; $display("[TB] FAIL single_latency: got %0t, expected %0t", dv_time - t0, 2*CLK_P + CLK_P/2 + 1);
    end
    if (recv_64bit !== 64'h0123_4567_89AB_CDEF) begin
      errors++; $display("[TB] FAIL single_hold: got %h, expected 0123456789abcdef", recv_64bit);
    end
    if (overflow !== 1'b0)    begin errors++; $display("[TB] FAIL single_overflow: got %b, expected 0", overflow); end
    if (frame_error !== 1'b0) begin errors++; $display("[TB] FAIL single_frame_error: got %b, expected 0", frame_error); end
  endtask

  task automatic test_wait_empty();
    int start;
    @(negedge CLK100MHZ);
    start = dv_count;
    recv_interrupt = 1'b1;
    repeat (5) @(negedge CLK100MHZ);
    exp_q.push_back(64'hFFFF_0000_FFFF_0000);
    send_frame(64'hFFFF_0000_FFFF_0000);
    repeat (30) @(negedge CLK100MHZ);
    checks += 2;
    if (dv_count - start != 1) begin
      errors++; $display("[TB] FAIL wait_empty_strobes: got %0d, expected 1", dv_count - start);
    end else if (dv_time - last_rise_t > (SYNC_STAGES+4)*CLK_P) begin
      errors++; $display("[TB] FAIL wait_empty_latency: got %0t, limit %0t", dv_time - last_rise_t, (SYNC_STAGES+4)*CLK_P);
    end
    recv_interrupt = 1'b0;
    repeat (4) @(negedge CLK100MHZ);
  endtask

  task automatic test_overflow();
    logic [63:0] frame;
    cs_low();
    for (int i = 0; i < 5; i++) begin
      frame = 64'hC0DE_0000_0000_0000 | 64'(i + 1);
      if (i < FIFO_DEPTH) exp_q.push_back(frame);
      send_bits(frame, 64);
    end
    cs_high();
    checks++;
    if (overflow !== 1'b1) begin errors++; $display("[TB] FAIL overflow_flag: got %b, expected 1", overflow); end
    send_frame(64'hDEAD_BEEF_DEAD_BEEF);
    checks++;
    if (miso_byte !== 8'h84) begin errors++; $display("[TB] FAIL overflow_status: got %b, expected 10000100", miso_byte); end
    for (int i = 0; i < 4; i++) pulse_request(1, "overflow_drain");
    pulse_request(0, "overflow_extra_request");
    pulse_clear();
    checks++;
    if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL overflow_clear: got %b, expected 0", overflow); end
  endtask

  task automatic test_abort();
    cs_low();
    send_bits(64'h1234_5678_9ABC_DEF0, 37);
    cs_high();
    checks++;
    if (frame_error !== 1'b1) begin errors++; $display("[TB] FAIL abort_flag: got %b, expected 1", frame_error); end
    exp_q.push_back(64'hA5A5_A5A5_A5A5_A5A5);
    send_frame(64'hA5A5_A5A5_A5A5_A5A5);
    checks++;
    if (miso_byte !== 8'h40) begin errors++; $display("[TB] FAIL abort_status: got %b, expected 01000000", miso_byte); end
    pulse_request(1, "abort_next_frame");
    pulse_clear();
    checks++;
    if (frame_error !== 1'b0) begin errors++; $display("[TB] FAIL abort_clear: got %b, expected 0", frame_error); end
  endtask

  task automatic test_status();
    logic [63:0] frame;
    for (int i = 0; i < 4; i++) begin
      frame = {$urandom, $urandom};
      exp_q.push_back(frame);
      send_frame(frame);
    end
    checks++;
    if (miso_byte !== 8'b0000_0011) begin errors++; $display("[TB] FAIL status_count: got %b, expected 00000011", miso_byte); end
    for (int i = 0; i < 4; i++) pulse_request(1, "status_drain");
  endtask

  task automatic test_reset_mid_frame();
    cs_low();
    send_bits(64'h5555_AAAA_5555_AAAA, 20);
    @(negedge CLK100MHZ);
    ck_rst = 1'b1;
    @(negedge CLK100MHZ);
    checks += 4;
    if (recv_64bit !== 64'h0) begin errors++; $display("[TB] FAIL midreset_data: got %h, expected 0", recv_64bit); end
    if (recv_dv !== 1'b0)     begin errors++; $display("[TB] FAIL midreset_dv: got %b, expected 0", recv_dv); end
    if (spi_miso !== 1'b0)    begin errors++; $display("[TB] FAIL midreset_miso: got %b, expected 0", spi_miso); end
    if (overflow !== 1'b0 || frame_error !== 1'b0) begin
      errors++; $display("[TB] FAIL midreset_flags: got %b%b, expected 00", overflow, frame_error);
    end
    spi_cs_n = 1'b1;
    repeat (3) @(negedge CLK100MHZ);
    ck_rst = 1'b0;
    repeat (4) @(negedge CLK100MHZ);
    exp_q.push_back(64'h0F1E_2D3C_4B5A_6978);
    send_frame(64'h0F1E_2D3C_4B5A_6978);
    checks++;
    if (frame_error !== 1'b0) begin errors++; $display("[TB] FAIL midreset_no_abort: got %b, expected 0", frame_error); end
    pulse_request(1, "midreset_next_frame");
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_wait_empty();
    test_overflow();
    test_abort();
    test_status();
    test_reset_mid_frame();
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("[TB] FAIL scoreboard_drain: got %0d pending, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
